// File: rtl/cp0_regfile_pkg.sv
// cp0_defs: register numbers, exception codes, bit positions and reset values for CP0
package cp0_defs;
    localparam logic [4:0] CP0_BADVADDR = 5'd8;
    localparam logic [4:0] CP0_COUNT    = 5'd9;
    localparam logic [4:0] CP0_COMPARE  = 5'd11;
    localparam logic [4:0] CP0_STATUS   = 5'd12;
    localparam logic [4:0] CP0_CAUSE    = 5'd13;
    localparam logic [4:0] CP0_EPC      = 5'd14;
    localparam logic [4:0] CP0_PRID     = 5'd15;
    localparam logic [4:0] CP0_CONFIG   = 5'd16;
    localparam logic [31:0] EXC_INT  = 32'h1;
    localparam logic [31:0] EXC_ADEL = 32'h4;
    localparam logic [31:0] EXC_ADES = 32'h5;
    localparam logic [31:0] EXC_SYS  = 32'h8;
    localparam logic [31:0] EXC_BP   = 32'h9;
    localparam logic [31:0] EXC_RI   = 32'ha;
    localparam logic [31:0] EXC_OV   = 32'hc;
    localparam logic [31:0] EXC_ERET = 32'he;
    localparam int STATUS_IE  = 0;
    localparam int STATUS_EXL = 1;
    localparam int CAUSE_BD   = 31;
    localparam int CAUSE_IP7  = 15;
    localparam logic [31:0] STATUS_RST   = 32'h0040_0000;
    localparam logic [31:0] STATUS_WMASK = 32'h0000_ff03;
    function automatic logic is_trap(input logic [31:0] code);
        return code == EXC_INT || code == EXC_ADEL || code == EXC_ADES || code == EXC_SYS ||
               code == EXC_BP || code == EXC_RI || code == EXC_OV;
    endfunction
endpackage

// File: rtl/cp0_regfile_timer.sv
// cp0_timer: Count (half clock rate), Compare and the sticky timer interrupt
module cp0_timer (
    input  logic        clk,
    input  logic        rst,
    input  logic        count_we_i,
    input  logic        compare_we_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    logic [31:0] count_q, count_d, compare_q, compare_d;
    logic        toggle_q, toggle_d, tint_q, tint_d;
    always_comb begin
        toggle_d  = count_we_i ? 1'b0 : ~toggle_q;
        count_d   = count_we_i ? wdata_i : count_q + {31'd0, toggle_q};
        compare_d = compare_we_i ? wdata_i : compare_q;
        // a Compare write acknowledges the interrupt and beats a same-cycle match
        tint_d    = compare_we_i ? 1'b0 : tint_q | (count_q == compare_q && compare_q != '0);
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            compare_q <= '0;
            toggle_q  <= 1'b0;
            tint_q    <= 1'b0;
        end else begin
            count_q   <= count_d;
            compare_q <= compare_d;
            toggle_q  <= toggle_d;
            tint_q    <= tint_d;
        end
    end
    assign count_o     = count_q;
    assign compare_o   = compare_q;
    assign timer_int_o = tint_q;
endmodule

// File: rtl/cp0_regfile.sv
// cp0_regfile: CP0 registers, MTC0/MFC0 access and exception/ERET commit
module cp0_regfile
    import cp0_defs::*;
#(
    parameter logic [31:0] PRID_VAL   = 32'h0000_4220,
    parameter logic [31:0] CONFIG_VAL = 32'h0000_8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        we_i,
    input  logic [4:0]  waddr_i,
    input  logic [4:0]  raddr_i,
    input  logic [31:0] data_i,
    input  logic [5:0]  int_i,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] current_inst_addr_i,
    input  logic        is_in_delayslot_i,
    input  logic [31:0] bad_addr_i,
    output logic [31:0] data_o,
    output logic [31:0] status_o,
    output logic [31:0] cause_o,
    output logic [31:0] epc_o,
    output logic [31:0] badvaddr_o,
    output logic [31:0] count_o,
    output logic [31:0] compare_o,
    output logic        timer_int_o
);
    logic [31:0] status_q, status_d, cause_q, cause_d, epc_q, epc_d, badvaddr_q, badvaddr_d;
    logic        mtc0, trap;
    // a faulting instruction never commits its own MTC0
    assign mtc0 = we_i && excepttype_i == '0;
    assign trap = is_trap(excepttype_i);
    cp0_timer u_timer (
        .clk          (clk),
        .rst          (rst),
        .count_we_i   (mtc0 && waddr_i == CP0_COUNT),
        .compare_we_i (mtc0 && waddr_i == CP0_COMPARE),
        .wdata_i      (data_i),
        .count_o      (count_o),
        .compare_o    (compare_o),
        .timer_int_o  (timer_int_o)
    );
    always_comb begin
        status_d            = status_q;
        cause_d             = cause_q;
        epc_d               = epc_q;
        badvaddr_d          = badvaddr_q;
        cause_d[CAUSE_IP7]  = int_i[5] | timer_int_o;
        cause_d[14:10]      = int_i[4:0];
        if (mtc0 && waddr_i == CP0_STATUS) status_d = (data_i & STATUS_WMASK) | (STATUS_RST & ~STATUS_WMASK);
        if (mtc0 && waddr_i == CP0_CAUSE) cause_d[9:8] = data_i[9:8];
        if (mtc0 && waddr_i == CP0_EPC) epc_d = data_i;
        if (trap) begin
            if (!status_q[STATUS_EXL]) begin
                epc_d             = is_in_delayslot_i ? current_inst_addr_i - 32'd4 : current_inst_addr_i;
                cause_d[CAUSE_BD] = is_in_delayslot_i;
            end
            status_d[STATUS_EXL] = 1'b1;
            cause_d[6:2]         = excepttype_i == EXC_INT ? 5'd0 : excepttype_i[4:0];
            if (excepttype_i == EXC_ADEL || excepttype_i == EXC_ADES) badvaddr_d = bad_addr_i;
        end
        if (excepttype_i == EXC_ERET) status_d[STATUS_EXL] = 1'b0;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q   <= STATUS_RST;
            cause_q    <= '0;
            epc_q      <= '0;
            badvaddr_q <= '0;
        end else begin
            status_q   <= status_d;
            cause_q    <= cause_d;
            epc_q      <= epc_d;
            badvaddr_q <= badvaddr_d;
        end
    end
    always_comb begin
        data_o = '0;
        case (raddr_i)
            CP0_BADVADDR: data_o = badvaddr_q;
            CP0_COUNT:    data_o = count_o;
            CP0_COMPARE:  data_o = compare_o;
            CP0_STATUS:   data_o = status_q;
            CP0_CAUSE:    data_o = cause_q;
            CP0_EPC:      data_o = epc_q;
            CP0_PRID:     data_o = PRID_VAL;
            CP0_CONFIG:   data_o = CONFIG_VAL;
            default:      data_o = '0;
        endcase
    end
    assign status_o   = status_q;
    assign cause_o    = cause_q;
    assign epc_o      = epc_q;
    assign badvaddr_o = badvaddr_q;
endmodule

// File: tb/tb_cp0_regfile.sv
// tb_cp0_regfile: directed vector table plus timer/count/reset sequences for cp0_regfile
module tb_cp0_regfile;
    logic        clk = 1'b0, rst = 1'b1, we = 1'b0, ds = 1'b0, timer_int;
    logic [4:0]  waddr = '0, raddr = '0;
    logic [5:0]  intr = '0;
    logic [31:0] wdata = '0, exc = '0, pc = '0, bad = '0;
    logic [31:0] rdata, status, cause, epc, badvaddr, count, compare;
    int n_cmp = 0, n_err = 0;
    bit seen;
    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] data;
        logic [5:0]  intr;
        logic [31:0] exc, pc;
        logic        ds;
        logic [31:0] bad;
        logic [4:0]  raddr;
        logic [31:0] e_status, e_cause, e_epc, e_bad, e_data;
    } vec_t;
    vec_t vecs[17];
    always #5 clk = ~clk;
    cp0_regfile dut (
        .clk(clk), .rst(rst), .we_i(we), .waddr_i(waddr), .raddr_i(raddr), .data_i(wdata),
        .int_i(intr), .excepttype_i(exc), .current_inst_addr_i(pc), .is_in_delayslot_i(ds),
        .bad_addr_i(bad), .data_o(rdata), .status_o(status), .cause_o(cause), .epc_o(epc),
        .badvaddr_o(badvaddr), .count_o(count), .compare_o(compare), .timer_int_o(timer_int)
    );
    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask
    task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
        @(negedge clk);
        we = 1'b1; waddr = a; wdata = d;
    endtask
    initial begin
        vecs[0]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h4, 32'hbfc00100, 1'b1, 32'h3,    5'd8,  32'h00400002, 32'h80000010, 32'hbfc000fc, 32'h3,    32'h3};
        vecs[1]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h8, 32'h80000010, 1'b0, 32'h0,    5'd14, 32'h00400002, 32'h80000020, 32'hbfc000fc, 32'h3,    32'hbfc000fc};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'he, 32'h0,        1'b0, 32'h0,    5'd12, 32'h00400000, 32'h80000020, 32'hbfc000fc, 32'h3,    32'h00400000};
        vecs[3]  = '{1'b1, 5'd14, 32'h12345678, 6'b000000, 32'hc, 32'h80000020, 1'b0, 32'h0,    5'd13, 32'h00400002, 32'h00000030, 32'h80000020, 32'h3,    32'h30};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'he, 32'h0,        1'b0, 32'h0,    5'd14, 32'h00400000, 32'h00000030, 32'h80000020, 32'h3,    32'h80000020};
        vecs[5]  = '{1'b1, 5'd12, 32'hffffffff, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd12, 32'h0040ff03, 32'h00000030, 32'h80000020, 32'h3,    32'h0040ff03};
        vecs[6]  = '{1'b1, 5'd13, 32'hffffffff, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd13, 32'h0040ff03, 32'h00000330, 32'h80000020, 32'h3,    32'h330};
        vecs[7]  = '{1'b1, 5'd12, 32'h0,        6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd12, 32'h00400000, 32'h00000330, 32'h80000020, 32'h3,    32'h00400000};
        vecs[8]  = '{1'b0, 5'd0,  32'h0,        6'b100001, 32'h0, 32'h0,        1'b0, 32'h0,    5'd15, 32'h00400000, 32'h00008730, 32'h80000020, 32'h3,    32'h4220};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        6'b011110, 32'h0, 32'h0,        1'b0, 32'h0,    5'd16, 32'h00400000, 32'h00007b30, 32'h80000020, 32'h3,    32'h8000};
        vecs[10] = '{1'b1, 5'd8,  32'hdeadbeef, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd8,  32'h00400000, 32'h00000330, 32'h80000020, 32'h3,    32'h3};
        vecs[11] = '{1'b1, 5'd15, 32'h0,        6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd15, 32'h00400000, 32'h00000330, 32'h80000020, 32'h3,    32'h4220};
        vecs[12] = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h3, 32'h80000030, 1'b1, 32'h77,   5'd20, 32'h00400000, 32'h00000330, 32'h80000020, 32'h3,    32'h0};
        vecs[13] = '{1'b1, 5'd14, 32'h12345678, 6'b000000, 32'h0, 32'h0,        1'b0, 32'h0,    5'd14, 32'h00400000, 32'h00000330, 32'h12345678, 32'h3,    32'h12345678};
        vecs[14] = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h1, 32'h80000040, 1'b0, 32'h0,    5'd13, 32'h00400002, 32'h00000300, 32'h80000040, 32'h3,    32'h300};
        vecs[15] = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'h5, 32'h80000050, 1'b1, 32'h1001, 5'd8,  32'h00400002, 32'h00000314, 32'h80000040, 32'h1001, 32'h1001};
        vecs[16] = '{1'b0, 5'd0,  32'h0,        6'b000000, 32'he, 32'h0,        1'b0, 32'h0,    5'd12, 32'h00400000, 32'h00000314, 32'h80000040, 32'h1001, 32'h00400000};
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        raddr = 5'd15;
        repeat (10) @(posedge clk);
        #1;
        check("count_after_10", count, 32'd5);
        check("status_reset", status, 32'h00400000);
        check("cause_reset", cause, 32'h0);
        check("epc_reset", epc, 32'h0);
        check("timer_reset", {31'd0, timer_int}, 32'd0);
        check("prid_read", rdata, 32'h00004220);
        mtc0(5'd9, 32'd0);
        mtc0(5'd11, 32'd3);
        @(negedge clk) we = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(posedge clk);
            #1;
            if (count == 32'd3) seen = 1'b1;
        end
        check("count_reaches_3", count, 32'd3);
        check("timer_not_early", {31'd0, timer_int}, 32'd0);
        @(posedge clk);
        #1;
        check("timer_set", {31'd0, timer_int}, 32'd1);
        @(posedge clk);
        #1;
        check("timer_held", {31'd0, timer_int}, 32'd1);
        check("cause_ip7_timer", {31'd0, cause[15]}, 32'd1);
        mtc0(5'd11, 32'd100);
        @(posedge clk);
        #1;
        check("timer_cleared", {31'd0, timer_int}, 32'd0);
        check("compare_100", compare, 32'd100);
        @(negedge clk) we = 1'b0;
        @(posedge clk);
        #1;
        check("cause_ip7_clear", {31'd0, cause[15]}, 32'd0);
        mtc0(5'd11, 32'd50);
        mtc0(5'd9, 32'd50);
        mtc0(5'd11, 32'd60);
        @(posedge clk);
        #1;
        check("cmp_write_beats_match", {31'd0, timer_int}, 32'd0);
        mtc0(5'd11, 32'd0);
        @(negedge clk) we = 1'b0;
        @(posedge clk);
        #1;
        check("timer_off_cmp0", {31'd0, timer_int}, 32'd0);
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            we = vecs[i].we; waddr = vecs[i].waddr; wdata = vecs[i].data; intr = vecs[i].intr;
            exc = vecs[i].exc; pc = vecs[i].pc; ds = vecs[i].ds; bad = vecs[i].bad; raddr = vecs[i].raddr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d_status", i), status, vecs[i].e_status);
            check($sformatf("v%0d_cause", i), cause, vecs[i].e_cause);
            check($sformatf("v%0d_epc", i), epc, vecs[i].e_epc);
            check($sformatf("v%0d_badvaddr", i), badvaddr, vecs[i].e_bad);
            check($sformatf("v%0d_rdata", i), rdata, vecs[i].e_data);
        end
        @(negedge clk);
        we = 1'b0; exc = '0; intr = '0; ds = 1'b0;
        mtc0(5'd9, 32'd1000);
        @(negedge clk);
        wdata = 32'd0; exc = 32'ha; pc = 32'h80000060;
        @(negedge clk);
        we = 1'b0; exc = '0;
        @(posedge clk);
        #1;
        check("count_runs_in_exc", count, 32'd1001);
        check("epc_ri", epc, 32'h80000060);
        check("status_exl_ri", status, 32'h00400002);
        @(negedge clk) exc = 32'he;
        @(negedge clk);
        exc = '0; rst = 1'b1; we = 1'b1; waddr = 5'd14; wdata = 32'haaaa5555;
        @(posedge clk);
        #1;
        check("midrst_epc", epc, 32'h0);
        check("midrst_status", status, 32'h00400000);
        check("midrst_cause", cause, 32'h0);
        check("midrst_count", count, 32'h0);
        @(negedge clk);
        rst = 1'b0; we = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_count0", count, 32'd0);
        @(posedge clk);
        #1;
        check("post_rst_count1", count, 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/cp0_regfile.md
Name: cp0_regfile

Overview:
- Coprocessor-0 register file. It consumes the memory-stage exception type produced by the exception prioritiser and commits the architectural effects of exceptions and ERET.
- Holds BadVAddr, Count, Compare, Status, Cause, EPC, PRId and Config.
- Generates the timer interrupt and latches external interrupt lines into Cause.IP.
- Its Status/Cause/EPC outputs feed back into the prioritiser and the MFC0 path.

Parameters:
- PRID_VAL, 32'h00004220, read-only PRId contents
- CONFIG_VAL, 32'h00008000, read-only Config contents

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset (fixed decision)
- we_i  in  1  MTC0 write enable
- waddr_i  in  5  MTC0 destination register number
- raddr_i  in  5  MFC0 source register number
- data_i  in  32  MTC0 write data
- int_i  in  6  external hardware interrupt lines, HW5..HW0
- excepttype_i  in  32  exception code from the prioritiser (0 = none)
- current_inst_addr_i  in  32  PC of the faulting instruction in the M stage
- is_in_delayslot_i  in  1  faulting instruction is in a branch delay slot
- bad_addr_i  in  32  faulting address for AdEL/AdES
- data_o  out  32  combinational MFC0 read data
- status_o  out  32  Status
- cause_o  out  32  Cause
- epc_o  out  32  EPC
- badvaddr_o  out  32  BadVAddr
- count_o  out  32  Count
- compare_o  out  32  Compare
- timer_int_o  out  1  timer interrupt pending

Behaviour:
- Register numbers: BadVAddr=8, Count=9, Compare=11, Status=12, Cause=13, EPC=14, PRId=15, Config=16. Any other raddr_i reads 0.
- Reset values:
  - Status = 32'h00400000 (BEV=1, EXL=0, IE=0).
  - Cause, EPC, BadVAddr, Count, Compare = 0; timer_int_o = 0; internal count toggle = 0.
- Read path: data_o is a combinational select of the current register values. There is no write bypass; the pipeline handles MTC0->MFC0 hazards.
- Count: increments by 1 every second clk, using an internal toggle bit. Wraps 32'hFFFFFFFF -> 0 silently. An MTC0 to Count loads data_i and clears the toggle.
- Timer interrupt:
  - timer_int_o is set the cycle after Count==Compare while Compare!=0.
  - It stays set until an MTC0 to Compare clears it.
  - If a Compare write and a match occur in the same cycle, the write wins and timer_int_o is cleared.
- Cause.IP every cycle:
  - Cause[15] <= int_i[5] | timer_int_o.
  - Cause[14:10] <= int_i[4:0].
  - Cause[9:8] (software IP) are written only by MTC0.
- MTC0 writable fields:
  - Status[15:8] (IM), Status[1] (EXL), Status[0] (IE). All other Status bits hold their reset values.
  - Cause[9:8] only.
  - EPC, Count and Compare are fully writable.
  - BadVAddr, PRId and Config ignore writes.
- Exception commit applies when excepttype_i != 0, in the same clk edge:
  - Codes 0x1, 0x4, 0x5, 0x8, 0x9, 0xa, 0xc:
    - If Status.EXL==0: EPC <= current_inst_addr_i - 4 when is_in_delayslot_i, else current_inst_addr_i; Cause.BD (bit 31) <= is_in_delayslot_i.
    - If Status.EXL==1: EPC and BD are unchanged.
    - Status.EXL <= 1.
    - Cause.ExcCode[6:2] <= 0 for 0x1, otherwise the code value.
  - 0x4 / 0x5: additionally BadVAddr <= bad_addr_i.
  - 0xe (ERET): Status.EXL <= 0; nothing else changes.
  - Any other nonzero code: no register change.
- Same-cycle MTC0 and exception: the MTC0 write is suppressed entirely, because the faulting instruction does not commit. Count still increments and Cause.IP still samples.
- Reset mid-operation: rst overrides all updates in that cycle, including the count tick.

Decomposition:
- Package cp0_defs holds:
  - register-number constants (CP0_BADVADDR ... CP0_CONFIG);
  - excepttype codes (EXC_INT=0x1, EXC_ADEL=0x4, EXC_ADES=0x5, EXC_SYS=0x8, EXC_BP=0x9, EXC_RI=0xa, EXC_OV=0xc, EXC_ERET=0xe);
  - Status/Cause bit-index constants;
  - reset values.
- One sub-module, cp0_timer, owns Count, the toggle bit, Compare and timer_int, with write ports for Count and Compare.

Test Plan:
- Reset, then 10 clk -> Count==5, Status==32'h00400000, timer_int_o=0, data_o(raddr=15)==PRID_VAL.
- MTC0 Compare=3 then run -> timer_int_o=1 the cycle after Count reaches 3 and Cause[15]=1. MTC0 Compare=100 -> timer_int_o=0 next cycle.
- excepttype_i=0x4, pc=32'hbfc00100, bad_addr=32'h00000003, delayslot=1 -> EPC=32'hbfc000fc, BD=1, ExcCode=4, EXL=1, BadVAddr=32'h00000003.
- With EXL=1, excepttype_i=0x8 at pc=32'h80000010 -> EPC unchanged, ExcCode=8. Then excepttype_i=0xe -> EXL=0.
- Same cycle: we_i=1 to EPC=32'h12345678 and excepttype_i=0xc at pc=32'h80000020 -> EPC=32'h80000020, ExcCode=0xc.
- MTC0 Status=32'hFFFFFFFF -> Status==32'h0040FF03. MTC0 Cause=32'hFFFFFFFF with int_i=0 -> Cause[9:8]=2'b11, other bits unchanged.
